// File: rtl/alu_opstage_pkg.sv
// Shared types and constants for the ALU operand stage: operand-select enums,
// the per-slot record, and the ALU opcode encodings.
package alu_opstage_pkg;

  localparam int OPS_XLEN   = 32;
  localparam int OPS_REG_AW = 5;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLT  = 4'd2;
  localparam logic [3:0] OP_SLTU = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;

  typedef enum logic [1:0] {
    OPA_RS1  = 2'b00,
    OPA_PC   = 2'b01,
    OPA_ZERO = 2'b10,
    OPA_RSVD = 2'b11
  } op_a_sel_e;

  typedef enum logic {
    OPB_RS2 = 1'b0,
    OPB_IMM = 1'b1
  } op_b_sel_e;

  typedef struct packed {
    logic                  valid;
    logic [OPS_REG_AW-1:0] rs1_addr;
    logic [OPS_REG_AW-1:0] rs2_addr;
    logic [OPS_XLEN-1:0]   rs1_val;
    logic [OPS_XLEN-1:0]   rs2_val;
    logic [OPS_XLEN-1:0]   pc;
    logic [OPS_XLEN-1:0]   imm;
    op_a_sel_e             a_sel;
    op_b_sel_e             b_sel;
    logic [3:0]            alu_op;
    logic [OPS_REG_AW-1:0] rd_addr;
    logic                  rd_wren;
  } opstage_entry_t;

endpackage

// File: rtl/opstage_slot.sv
// One buffer slot of the operand stage. Whatever the slot will hold next
// (new load or retained contents) sees the write-back snoop before being stored.
module opstage_slot
  import alu_opstage_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  load,
  input  logic                  clear,
  input  opstage_entry_t        load_entry,
  input  logic                  wb_wren,
  input  logic [OPS_REG_AW-1:0] wb_addr,
  input  logic [OPS_XLEN-1:0]   wb_data,
  output opstage_entry_t        entry
);

  opstage_entry_t base;
  opstage_entry_t next_entry;
  logic           wb_hit;

  // Capture-time forwarding and hold-time snooping are the same operation,
  // applied to whichever record is about to be stored; x0 never matches.
  always_comb begin
    wb_hit     = wb_wren && (wb_addr != '0);
    base       = load ? load_entry : entry;
    next_entry = base;
    if (clear && !load) begin
      next_entry.valid = 1'b0;
    end
    if (base.valid && wb_hit && (wb_addr == base.rs1_addr)) begin
      next_entry.rs1_val = wb_data;
    end
    if (base.valid && wb_hit && (wb_addr == base.rs2_addr)) begin
      next_entry.rs2_val = wb_data;
    end
    if (flush) begin
      next_entry.valid = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry <= '0;
    end else begin
      entry <= next_entry;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Two-slot skid buffer in front of the ALU with write-back forwarding/snooping.
// Define ALU_OPSTAGE_PERF_EN to add the o_stall_cnt backpressure counter.
module alu_operand_stage
  import alu_opstage_pkg::*;
#(
  parameter int XLEN   = OPS_XLEN,
  parameter int REG_AW = OPS_REG_AW
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_flush,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [REG_AW-1:0] i_rs1_addr,
  input  logic [REG_AW-1:0] i_rs2_addr,
  input  logic [XLEN-1:0]   i_rs1_data,
  input  logic [XLEN-1:0]   i_rs2_data,
  input  logic [XLEN-1:0]   i_pc,
  input  logic [XLEN-1:0]   i_imm,
  input  logic [1:0]        i_op_a_sel,
  input  logic              i_op_b_sel,
  input  logic [3:0]        i_alu_op,
  input  logic [REG_AW-1:0] i_rd_addr,
  input  logic              i_rd_wren,
  input  logic              i_wb_wren,
  input  logic [REG_AW-1:0] i_wb_addr,
  input  logic [XLEN-1:0]   i_wb_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [XLEN-1:0]   o_op_a,
  output logic [XLEN-1:0]   o_op_b,
  output logic [3:0]        o_alu_op,
  output logic [REG_AW-1:0] o_rd_addr,
  output logic              o_rd_wren
`ifdef ALU_OPSTAGE_PERF_EN
  ,
  output logic [31:0]       o_stall_cnt
`endif
);

  opstage_entry_t in_entry;
  opstage_entry_t m_q;
  opstage_entry_t s_q;
  opstage_entry_t m_src;
  logic           accept;
  logic           m_xfer;
  logic           m_load;
  logic           m_clear;
  logic           s_load;
  logic           s_clear;

  always_comb begin
    in_entry          = '0;
    in_entry.valid    = 1'b1;
    in_entry.rs1_addr = i_rs1_addr;
    in_entry.rs2_addr = i_rs2_addr;
    in_entry.rs1_val  = i_rs1_data;
    in_entry.rs2_val  = i_rs2_data;
    in_entry.pc       = i_pc;
    in_entry.imm      = i_imm;
    in_entry.a_sel    = op_a_sel_e'(i_op_a_sel);
    in_entry.b_sel    = op_b_sel_e'(i_op_b_sel);
    in_entry.alu_op   = i_alu_op;
    in_entry.rd_addr  = i_rd_addr;
    in_entry.rd_wren  = i_rd_wren;
  end

  // S is a register, so ready is registered; accept can never coincide with S full.
  assign o_in_ready  = !s_q.valid;
  assign o_out_valid = m_q.valid;
  assign accept      = i_in_valid && o_in_ready;
  assign m_xfer      = m_q.valid && i_out_ready;

  // Slot steering: S refills M first, otherwise new input goes to the free slot.
  always_comb begin
    m_load  = 1'b0;
    m_clear = 1'b0;
    s_load  = 1'b0;
    s_clear = 1'b0;
    m_src   = in_entry;
    if (m_xfer && s_q.valid) begin
      m_load  = 1'b1;
      m_src   = s_q;
      s_clear = 1'b1;
    end else if (accept && (!m_q.valid || m_xfer)) begin
      m_load = 1'b1;
    end else if (accept) begin
      s_load = 1'b1;
    end else if (m_xfer) begin
      m_clear = 1'b1;
    end
  end

  opstage_slot u_slot_m (
    .clk        (i_clk),
    .reset      (i_reset),
    .flush      (i_flush),
    .load       (m_load),
    .clear      (m_clear),
    .load_entry (m_src),
    .wb_wren    (i_wb_wren),
    .wb_addr    (i_wb_addr),
    .wb_data    (i_wb_data),
    .entry      (m_q)
  );

  opstage_slot u_slot_s (
    .clk        (i_clk),
    .reset      (i_reset),
    .flush      (i_flush),
    .load       (s_load),
    .clear      (s_clear),
    .load_entry (in_entry),
    .wb_wren    (i_wb_wren),
    .wb_addr    (i_wb_addr),
    .wb_data    (i_wb_data),
    .entry      (s_q)
  );

  // Outputs are forced to zero whenever M holds nothing.
  always_comb begin
    o_op_a    = '0;
    o_op_b    = '0;
    o_alu_op  = '0;
    o_rd_addr = '0;
    o_rd_wren = 1'b0;
    if (m_q.valid) begin
      case (m_q.a_sel)
        OPA_RS1: o_op_a = m_q.rs1_val;
        OPA_PC:  o_op_a = m_q.pc;
        default: o_op_a = '0;
      endcase
      o_op_b    = (m_q.b_sel == OPB_IMM) ? m_q.imm : m_q.rs2_val;
      o_alu_op  = m_q.alu_op;
      o_rd_addr = m_q.rd_addr;
      o_rd_wren = m_q.rd_wren;
    end
  end

`ifdef ALU_OPSTAGE_PERF_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_stall_cnt <= '0;
    end else if (i_flush) begin
      o_stall_cnt <= '0;
    end else if (m_q.valid && !i_out_ready && (o_stall_cnt != 32'hFFFF_FFFF)) begin
      o_stall_cnt <= o_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Pipeline stage directly upstream of the 32-bit ALU (10 ops: ADD, SUB, SLT, SLTU, XOR, OR, AND, SLL, SRL, SRA).
- Takes decoded instructions from ID and registers them into a 2-slot skid buffer (main + skid) with valid/ready handshakes.
- Resolves operand sources and write-back forwarding, then drives the ALU's op_a/op_b/alu_op inputs plus the rd tag for later stages.

Parameters:
- XLEN, 32, operand/data width.
- REG_AW, 5, register address width.

Ports:
- i_clk  in  1  clock; all state on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_flush  in  1  synchronous pipeline flush.
- i_in_valid  in  1  ID has an instruction.
- o_in_ready  out  1  stage can accept; registered.
- i_rs1_addr, i_rs2_addr  in  REG_AW  source register indices.
- i_rs1_data, i_rs2_data  in  XLEN  register-file read data.
- i_pc  in  XLEN  instruction PC.
- i_imm  in  XLEN  sign-extended immediate.
- i_op_a_sel  in  2  00 rs1, 01 pc, 10 zero, 11 zero (reserved).
- i_op_b_sel  in  1  0 rs2, 1 imm.
- i_alu_op  in  4  ALU opcode, passed through unchanged.
- i_rd_addr  in  REG_AW  destination register.
- i_rd_wren  in  1  destination write enable.
- i_wb_wren  in  1  write-back port writes this cycle.
- i_wb_addr  in  REG_AW  write-back register.
- i_wb_data  in  XLEN  write-back data.
- o_out_valid  out  1  ALU operands valid.
- i_out_ready  in  1  downstream accepts.
- o_op_a, o_op_b  out  XLEN  ALU operands.
- o_alu_op  out  4  ALU opcode.
- o_rd_addr  out  REG_AW  destination tag.
- o_rd_wren  out  1  destination write enable.

Behaviour:
- Storage:
  - Slots M (drives outputs) and S (skid).
  - Each slot stores: valid, rs1/rs2 addr, rs1/rs2 value, pc, imm, sel fields, alu_op, rd_addr, rd_wren.
- Handshake:
  - Accept = i_in_valid & o_in_ready.
  - Transfer = o_out_valid & i_out_ready.
  - o_out_valid = M.valid.
  - o_in_ready = !S.valid, registered.
- Capture:
  - M empty, or M transferring while S empty: accept writes M.
  - M valid and not transferring: accept writes S.
  - Transfer with S valid: S moves to M and S clears.
- Latency and ordering:
  - 1 cycle from accept to o_out_valid.
  - Throughput 1 instruction/cycle with no backpressure.
  - Strict in-order; no loss, no duplication.
- Forwarding at capture: if i_wb_wren & i_wb_addr!=0 & i_wb_addr==rsN_addr, store i_wb_data instead of i_rsN_data.
- Snoop while held:
  - Each cycle, every valid slot whose rsN_addr matches a qualifying WB write updates its stored rsN value.
  - A slot moving S->M in the same cycle takes the snooped value.
  - x0 is never forwarded or snooped.
- Operand mux (combinational from M):
  - o_op_a = rs1 / pc / 0 per sel.
  - o_op_b = rs2 / imm per sel.
- Output gating: all data outputs are 0 when o_out_valid=0.
- Flush:
  - i_flush clears M.valid and S.valid at the next edge.
  - A same-cycle accept is discarded.
  - Flush has priority over all other events.
  - o_in_ready=1 the cycle after a flush.
- Reset:
  - Asynchronous; takes effect mid-operation.
  - All slot fields = 0, o_out_valid = 0, o_in_ready = 1, all outputs = 0.
- Opcodes 10..15 pass through untouched; no checking.

Optional Feature:
- Macro: ALU_OPSTAGE_PERF_EN.
- Defined:
  - Adds output o_stall_cnt [31:0], incremented each cycle o_out_valid & !i_out_ready.
  - Saturates at 0xFFFFFFFF.
  - Cleared by i_reset and i_flush.
- Undefined: port and counter are absent; no other behaviour changes.

Decomposition:
- Package alu_opstage_pkg:
  - op_a_sel_e and op_b_sel_e enums.
  - opstage_entry_t struct (slot contents).
  - ALU opcode localparams ADD=4'd0 .. SRA=4'd9.
- Sub-module opstage_slot: one slot register plus WB snoop and update logic, instantiated twice (M, S).

Test Plan:
- Back-to-back flow: 4 instrs (rs1=5, rs2=7, op=ADD, sel rs1/rs2), i_out_ready=1 -> o_op_a=5, o_op_b=7 from cycle+1; 4 consecutive valid cycles; o_in_ready stays 1.
- Capture forward: rs1_addr=3, rs1_data=0x11, WB x3=0x22 same cycle -> o_op_a=0x22. Repeat with WB addr 0, data 0xFF -> o_op_a=rs1_data.
- Backpressure:
  - Stimulus: i_out_ready=0, send A, B, C.
  - o_in_ready=0 after B; C is held at the input.
  - Release i_out_ready -> outputs A, B, C in order with no gaps.
  - PERF_EN: o_stall_cnt equals the number of stalled cycles (3).
- Snoop while held:
  - Stimulus: B in S with rs2_addr=5, sel rs2; WB x5=0xDEAD while stalled.
  - B's o_op_b=0xDEAD.
  - Same with sel imm=0x10: o_op_b=0x10.
- Flush: M and S full, i_flush=1 with i_in_valid=1 -> next cycle o_out_valid=0, o_in_ready=1, flushed input never appears.
- Async reset mid-stall:
  - Stimulus: assert i_reset between clock edges.
  - Outputs go to 0 and o_out_valid to 0 immediately.
  - After deassert, o_in_ready=1 and the first new instruction flows normally.
